// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select encodings, reset/exception
// vectors, legal instruction-memory window and the address-error exception code.
package if_stage_pkg;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF  = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_ADEL = 5'd4;

  // Packs {BD, valid, ExcCode} into the 7-bit ExCode[8:2] field.
  function automatic logic [8:2] pack_excode(input logic bd, input logic vld,
                                             input logic [4:0] code);
    pack_excode = {bd, vld, code};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: imem address/data, decode-side redirect controls, CP0 redirects
// and the F/D register outputs. The slave modport is the fetch stage itself.
interface if_stage_if;
  logic [31:0] Instr_F_I;
  logic [1:0]  NPCOp_F_I;
  logic [31:0] PC_D_I;
  logic [25:0] Imm26_F_I;
  logic [31:0] RegTarget_F_I;
  logic        isBranch_D_I;
  logic        Stall_F_I;
  logic        Req_F_I;
  logic        eret_F_I;
  logic [31:0] EPC_F_I;
  logic [31:0] PC_F_O;
  logic [31:0] Instr_D_O;
  logic [31:0] PC_D_O;
  logic [8:2]  ExCode_D_O;

  modport master (
    output Instr_F_I, NPCOp_F_I, PC_D_I, Imm26_F_I, RegTarget_F_I,
           isBranch_D_I, Stall_F_I, Req_F_I, eret_F_I, EPC_F_I,
    input  PC_F_O, Instr_D_O, PC_D_O, ExCode_D_O
  );

  modport slave (
    input  Instr_F_I, NPCOp_F_I, PC_D_I, Imm26_F_I, RegTarget_F_I,
           isBranch_D_I, Stall_F_I, Req_F_I, eret_F_I, EPC_F_I,
    output PC_F_O, Instr_D_O, PC_D_O, ExCode_D_O
  );
endinterface

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC selection from decode's branch/jump decision, plus the
// fetch-address fault check on the current PC.
module if_stage_npc_calc
  import if_stage_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic [31:0] pc_dec,
  input  logic [25:0] imm26,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        fault
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_dec_plus4;
  logic [31:0] br_offset;

  assign pc_plus4     = pc + 32'd4;
  assign pc_dec_plus4 = pc_dec + 32'd4;
  assign br_offset    = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (npc_op_e'(npc_op))
      NPC_PC4: next_pc = pc_plus4;
      NPC_BR:  next_pc = pc_dec_plus4 + br_offset;
      NPC_J:   next_pc = {pc_dec_plus4[31:28], imm26, 2'b00};
      NPC_JR:  next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // Wrapped sums land outside the window and fault here rather than trapping.
  assign fault = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LIMIT);

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, redirect priority (exception > eret > stall >
// normal) and the F/D pipeline register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEF,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [8:2]  fd_exc_q, fd_exc_d;

  logic [31:0] next_pc;
  logic        fault;

  if_stage_npc_calc #(
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_LIMIT (IMEM_LIMIT)
  ) u_npc (
    .pc         (pc_q),
    .npc_op     (bus.NPCOp_F_I),
    .pc_dec     (bus.PC_D_I),
    .imm26      (bus.Imm26_F_I),
    .reg_target (bus.RegTarget_F_I),
    .next_pc    (next_pc),
    .fault      (fault)
  );

  always_comb begin
    pc_d       = pc_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    fd_exc_d   = fd_exc_q;
    if (bus.Req_F_I) begin
      pc_d       = EXC_ENTRY;
      fd_instr_d = 32'h0;
      fd_pc_d    = EXC_ENTRY;
      fd_exc_d   = '0;
    end else if (bus.eret_F_I) begin
      // eret has no delay slot, so whatever was fetched alongside it is dropped.
      pc_d       = bus.EPC_F_I;
      fd_instr_d = 32'h0;
      fd_pc_d    = bus.EPC_F_I;
      fd_exc_d   = '0;
    end else if (!bus.Stall_F_I) begin
      pc_d       = next_pc;
      fd_instr_d = fault ? 32'h0 : bus.Instr_F_I;
      fd_pc_d    = pc_q;
      fd_exc_d   = pack_excode(bus.isBranch_D_I, fault, fault ? EXC_ADEL : 5'd0);
    end
  end

  // ---- F/D pipeline register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      fd_instr_q <= 32'h0;
      fd_pc_q    <= RESET_PC;
      fd_exc_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_exc_q   <= fd_exc_d;
    end
  end

  assign bus.PC_F_O     = pc_q;
  assign bus.Instr_D_O  = fd_instr_q;
  assign bus.PC_D_O     = fd_pc_q;
  assign bus.ExCode_D_O = fd_exc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage: reset, sequential fetch, branch/jump/jr,
// stall, fetch faults and exception/eret redirects.
module tb_if_stage;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  if_stage_if bus ();

  if_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    imem = a ^ 32'hDEAD_0000;
  endfunction

  assign bus.Instr_F_I = imem(bus.PC_F_O);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fd(input string tag, input logic [31:0] pc_f,
                        input logic [31:0] instr, input logic [31:0] pc_dd,
                        input logic [6:0] exc);
    chk({tag, ".pc_f"},  bus.PC_F_O, pc_f);
    chk({tag, ".instr"}, bus.Instr_D_O, instr);
    chk({tag, ".pc_d"},  bus.PC_D_O, pc_dd);
    chk({tag, ".exc"},   {25'h0, bus.ExCode_D_O}, {25'h0, exc});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.NPCOp_F_I     = 2'b00;
    bus.PC_D_I        = 32'h0;
    bus.Imm26_F_I     = 26'h0;
    bus.RegTarget_F_I = 32'h0;
    bus.isBranch_D_I  = 1'b0;
    bus.Stall_F_I     = 1'b0;
    bus.Req_F_I       = 1'b0;
    bus.eret_F_I      = 1'b0;
    bus.EPC_F_I       = 32'h0;

    #12 reset = 1'b1;
    tick();
    tick();
    // Mid-cycle asynchronous reset takes effect without a clock edge.
    #2 reset = 1'b0;
    #1;
    chk_fd("rst", 32'h3000, 32'h0, 32'h3000, 7'h00);
    #1 reset = 1'b1;

    tick(); chk_fd("seq1", 32'h3004, imem(32'h3000), 32'h3000, 7'h00);
    tick(); chk_fd("seq2", 32'h3008, imem(32'h3004), 32'h3004, 7'h00);
    tick(); chk_fd("seq3", 32'h300C, imem(32'h3008), 32'h3008, 7'h00);

    // Backward branch from decode PC 3010, slot at 300C carries BD.
    bus.NPCOp_F_I = 2'b01; bus.PC_D_I = 32'h3010; bus.Imm26_F_I = 26'h000FFFC;
    bus.isBranch_D_I = 1'b1;
    tick(); chk_fd("br", 32'h3004, imem(32'h300C), 32'h300C, 7'h40);
    bus.NPCOp_F_I = 2'b00; bus.isBranch_D_I = 1'b0;
    tick(); chk_fd("br_after", 32'h3008, imem(32'h3004), 32'h3004, 7'h00);

    // Jump: {(3008+4)[31:28], 26'hC08, 00} = 3020.
    bus.NPCOp_F_I = 2'b10; bus.PC_D_I = 32'h3008; bus.Imm26_F_I = 26'h0000C08;
    tick(); chk("j.pc_f", bus.PC_F_O, 32'h3020);
    bus.NPCOp_F_I = 2'b00;

    bus.Stall_F_I = 1'b1;
    tick(); chk_fd("stall1", 32'h3020, imem(32'h3008), 32'h3008, 7'h00);
    tick(); chk_fd("stall2", 32'h3020, imem(32'h3008), 32'h3008, 7'h00);
    bus.Stall_F_I = 1'b0;
    tick(); chk_fd("resume", 32'h3024, imem(32'h3020), 32'h3020, 7'h00);

    // jr to a misaligned target faults on the following fetch.
    bus.NPCOp_F_I = 2'b11; bus.RegTarget_F_I = 32'h3002;
    tick(); chk("jr_mis.pc_f", bus.PC_F_O, 32'h3002);
    bus.NPCOp_F_I = 2'b00;
    tick(); chk_fd("jr_mis", 32'h3006, 32'h0, 32'h3002, 7'h24);

    bus.NPCOp_F_I = 2'b11; bus.RegTarget_F_I = 32'h7000;
    tick(); chk_fd("jr_hi_slot", 32'h7000, 32'h0, 32'h3006, 7'h24);
    bus.NPCOp_F_I = 2'b00;
    tick(); chk_fd("jr_hi", 32'h7004, 32'h0, 32'h7000, 7'h24);

    // Top of the legal window is still fetchable; BD rides along with the fault bits.
    bus.NPCOp_F_I = 2'b11; bus.RegTarget_F_I = 32'h6FFC; bus.isBranch_D_I = 1'b1;
    tick(); chk_fd("lim_slot", 32'h6FFC, 32'h0, 32'h7004, 7'h64);
    bus.NPCOp_F_I = 2'b00; bus.isBranch_D_I = 1'b0;
    tick(); chk_fd("lim", 32'h7000, imem(32'h6FFC), 32'h6FFC, 7'h00);

    bus.NPCOp_F_I = 2'b11; bus.RegTarget_F_I = 32'h2FFC;
    tick();
    bus.NPCOp_F_I = 2'b00;
    tick(); chk_fd("below", 32'h3000, 32'h0, 32'h2FFC, 7'h24);

    // Wrap past FFFFFFFC lands at 0, which faults via the range check.
    bus.NPCOp_F_I = 2'b11; bus.RegTarget_F_I = 32'hFFFF_FFFC;
    tick();
    bus.NPCOp_F_I = 2'b00;
    tick(); chk_fd("wrap1", 32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 7'h24);
    tick(); chk_fd("wrap2", 32'h0000_0004, 32'h0, 32'h0000_0000, 7'h24);

    // Exception request wins over stall and a pending branch.
    bus.Stall_F_I = 1'b1; bus.Req_F_I = 1'b1; bus.NPCOp_F_I = 2'b01;
    bus.PC_D_I = 32'h3010; bus.Imm26_F_I = 26'h0000010; bus.isBranch_D_I = 1'b1;
    tick(); chk_fd("req_stall", 32'h4180, 32'h0, 32'h4180, 7'h00);
    bus.Stall_F_I = 1'b0; bus.Req_F_I = 1'b0; bus.NPCOp_F_I = 2'b00; bus.isBranch_D_I = 1'b0;
    tick(); chk_fd("req_after", 32'h4184, imem(32'h4180), 32'h4180, 7'h00);

    bus.eret_F_I = 1'b1; bus.EPC_F_I = 32'h3040;
    tick();
    chk("eret.pc_f", bus.PC_F_O, 32'h3040);
    chk("eret.instr", bus.Instr_D_O, 32'h0);
    chk("eret.exc", {25'h0, bus.ExCode_D_O}, 32'h0);

    bus.Req_F_I = 1'b1;
    tick(); chk_fd("eret_req", 32'h4180, 32'h0, 32'h4180, 7'h00);
    bus.Req_F_I = 1'b0; bus.eret_F_I = 1'b0;
    tick(); chk("idle.pc_f", bus.PC_F_O, 32'h4184);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
